// File: rtl/pkg_defines.sv
// Shared definitions for the main memory controller: FSM states, request op, line-offset helper.
// Ports: none (package).
// Optional feature macro used by the importing files: MAIN_MEMORY_BYTE_STROBE_EN.
package pkg_defines;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } op_e;

   // Width of the latency down-counter; comfortably above any practical latency.
   localparam int CNT_W = 16;

   localparam int DEFAULT_LINE_BYTES = 16;

   function automatic int line_offset_bits(input int line_bytes);
      return $clog2(line_bytes);
   endfunction

   localparam int LINE_OFFSET_BITS = line_offset_bits(DEFAULT_LINE_BYTES);

endpackage

// File: rtl/main_memory_array.sv
// Single-port synchronous line RAM with per-byte write mask and registered read data.
// Ports: i_clock/i_reset, i_rd_en/i_wr_en, i_idx line index, i_wr_data/i_byte_mask write line,
//        o_rd_data registered read line (cleared by reset; storage itself is never cleared).
module main_memory_array #(
   parameter int LINE_BYTES  = 16,
   parameter int DEPTH_LINES = 1024
) (
   input  logic                           i_clock,
   input  logic                           i_reset,
   input  logic                           i_rd_en,
   input  logic                           i_wr_en,
   input  logic [$clog2(DEPTH_LINES)-1:0] i_idx,
   input  logic [LINE_BYTES*8-1:0]        i_wr_data,
   input  logic [LINE_BYTES-1:0]          i_byte_mask,
   output logic [LINE_BYTES*8-1:0]        o_rd_data
);

   logic [LINE_BYTES*8-1:0] mem_q [DEPTH_LINES];
   logic [LINE_BYTES*8-1:0] rd_data_q;
   logic [LINE_BYTES*8-1:0] rd_data_d;

   always_comb begin
      rd_data_d = rd_data_q;
      if (i_rd_en) begin
         rd_data_d = mem_q[i_idx];
      end
   end

   // Output register only; maps onto a BRAM output register with sync reset.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   // Storage has no reset; the caller gates i_wr_en with reset.
   always_ff @(posedge i_clock) begin
      for (int b = 0; b < LINE_BYTES; b++) begin
         if (i_wr_en && i_byte_mask[b]) begin
            mem_q[i_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
         end
      end
   end

   assign o_rd_data = rd_data_q;

endmodule

// File: rtl/main_memory_ctrl.sv
// Line-wide backing-store controller with fixed read/write latency and busy/done handshake.
// Ports: i_clock, i_reset (sync, active-high), i_address/i_read/i_write/i_data request,
//        o_data read line, o_busy, o_done pulse, o_error pulse (read+write together).
// Optional: MAIN_MEMORY_BYTE_STROBE_EN adds i_byte_en for per-byte write enables.
module main_memory_ctrl
   import pkg_defines::*;
#(
   parameter int LINE_BYTES    = 16,
   parameter int DEPTH_LINES   = 1024,
   parameter int READ_LATENCY  = 4,
   parameter int WRITE_LATENCY = 2
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic [31:0]             i_address,
   input  logic                    i_read,
   input  logic                    i_write,
   input  logic [LINE_BYTES*8-1:0] i_data,
`ifdef MAIN_MEMORY_BYTE_STROBE_EN
   input  logic [LINE_BYTES-1:0]   i_byte_en,
`endif
   output logic [LINE_BYTES*8-1:0] o_data,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_error
);

   localparam int OFF_BITS = line_offset_bits(LINE_BYTES);
   localparam int IDX_BITS = $clog2(DEPTH_LINES);
   localparam int LW       = LINE_BYTES * 8;

   // Counter is loaded with latency-2: the accept edge and the DONE-entry edge are
   // both part of the latency, the remaining edges are spent in WAIT.
   function automatic logic [CNT_W-1:0] lat_init(input int lat);
      return (lat >= 2) ? CNT_W'(lat - 2) : '0;
   endfunction

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_BITS-1:0]   idx_q, idx_d;
   op_e                   op_q, op_d;
   logic [LW-1:0]         wdata_q, wdata_d;
   logic [LINE_BYTES-1:0] be_q, be_d;
   logic                  err_q, err_d;

   logic [IDX_BITS-1:0]   req_idx;
   logic [LINE_BYTES-1:0] req_be;
   int                    req_lat;

   logic                  mem_rd_en;
   logic                  mem_wr_en;
   logic [IDX_BITS-1:0]   mem_idx;
   logic [LW-1:0]         mem_wdata;
   logic [LINE_BYTES-1:0] mem_be;
   logic [LW-1:0]         mem_rdata;

   // Upper address bits alias; offset bits are ignored.
   assign req_idx = i_address[OFF_BITS +: IDX_BITS];
   logic unused_addr;
   assign unused_addr = ^{i_address[31:OFF_BITS+IDX_BITS], i_address[OFF_BITS-1:0]};

`ifdef MAIN_MEMORY_BYTE_STROBE_EN
   assign req_be = i_byte_en;
`else
   assign req_be = '1;
`endif

   // State register (plus datapath latches).
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         op_q    <= OP_READ;
         wdata_q <= '0;
         be_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         op_q    <= op_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         err_q   <= err_d;
      end
   end

   // Next-state and array-access logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      op_d      = op_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      err_d     = 1'b0;
      req_lat   = i_write ? WRITE_LATENCY : READ_LATENCY;
      mem_rd_en = 1'b0;
      mem_wr_en = 1'b0;
      mem_idx   = idx_q;
      mem_wdata = wdata_q;
      mem_be    = be_q;

      case (state_q)
         IDLE: begin
            if (i_read && i_write) begin
               err_d = 1'b1;
            end else if (i_read || i_write) begin
               op_d    = i_write ? OP_WRITE : OP_READ;
               idx_d   = req_idx;
               wdata_d = i_data;
               be_d    = req_be;
               if (req_lat == 1) begin
                  // Single-cycle latency: the array access happens on the accept edge
                  // itself, so it must use the live request rather than the latches.
                  state_d   = DONE;
                  mem_idx   = req_idx;
                  mem_wdata = i_data;
                  mem_be    = req_be;
                  mem_rd_en = !i_write;
                  mem_wr_en = i_write;
               end else begin
                  state_d = WAIT;
                  cnt_d   = lat_init(req_lat);
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d   = DONE;
               mem_rd_en = (op_q == OP_READ);
               mem_wr_en = (op_q == OP_WRITE);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Reset wins over a commit landing on the same edge.
      if (i_reset) begin
         mem_rd_en = 1'b0;
         mem_wr_en = 1'b0;
      end
   end

   // Outputs.
   always_comb begin
      o_busy  = (state_q != IDLE);
      o_done  = (state_q == DONE);
      o_error = err_q;
      o_data  = mem_rdata;
   end

   main_memory_array #(
      .LINE_BYTES  (LINE_BYTES),
      .DEPTH_LINES (DEPTH_LINES)
   ) u_array (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_rd_en     (mem_rd_en),
      .i_wr_en     (mem_wr_en),
      .i_idx       (mem_idx),
      .i_wr_data   (mem_wdata),
      .i_byte_mask (mem_be),
      .o_rd_data   (mem_rdata)
   );

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Directed bench for main_memory_ctrl with default parameters (16-byte lines, 1024 lines,
// read latency 4, write latency 2). Byte-strobe cases run when MAIN_MEMORY_BYTE_STROBE_EN is defined.
module tb_main_memory_ctrl;

   logic         i_clock;
   logic         i_reset;
   logic [31:0]  i_address;
   logic         i_read;
   logic         i_write;
   logic [127:0] i_data;
   logic [15:0]  i_byte_en;
   logic [127:0] o_data;
   logic         o_busy;
   logic         o_done;
   logic         o_error;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [127:0] L1 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEBABE;
   localparam logic [127:0] L2 = 128'h11112222_33334444_55556666_77778888;
   localparam logic [127:0] L3 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
   localparam logic [127:0] L4 = 128'h01020304_05060708_090A0B0C_0D0E0F10;
   localparam logic [127:0] L5 = 128'hFEEDFACE_FEEDFACE_FEEDFACE_FEEDFACE;

   main_memory_ctrl dut (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_address (i_address),
      .i_read    (i_read),
      .i_write   (i_write),
      .i_data    (i_data),
`ifdef MAIN_MEMORY_BYTE_STROBE_EN
      .i_byte_en (i_byte_en),
`endif
      .o_data    (o_data),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_error   (o_error)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one request, scramble the inputs after accept, and measure the edges
   // from accept to the first cycle with o_done high (expected LAT-1).
   task automatic do_op(input string tag, input bit wr, input logic [31:0] addr,
                        input logic [127:0] data, input logic [15:0] be,
                        input int exp_edges, input bit chk_data, input logic [127:0] exp_data);
      int k;
      k = -1;
      @(negedge i_clock);
      i_address = addr;
      i_data    = data;
      i_byte_en = be;
      i_read    = !wr;
      i_write   = wr;
      @(posedge i_clock);
      #1;
      chk({tag, "_busy_acc"}, {127'd0, o_busy}, 128'd1);
      i_read    = 1'b0;
      i_write   = 1'b0;
      i_address = addr ^ 32'h0000_3FF0;
      i_data    = ~data;
      i_byte_en = ~be;
      for (int c = 1; c <= 20; c++) begin
         @(posedge i_clock);
         #1;
         if (o_done) begin
            k = c;
            break;
         end
      end
      chk({tag, "_lat"}, 128'(k), 128'(exp_edges));
      if (chk_data) chk({tag, "_data"}, o_data, exp_data);
      @(posedge i_clock);
      #1;
      chk({tag, "_idle"}, {126'd0, o_busy, o_done}, 128'd0);
   endtask

   initial begin
      logic [15:0] done_v;
      logic [15:0] busy_v;
      i_reset   = 1'b1;
      i_address = '0;
      i_read    = 1'b0;
      i_write   = 1'b0;
      i_data    = '0;
      i_byte_en = '1;

      // Reset: outputs quiet throughout, o_data cleared.
      for (int c = 0; c < 3; c++) begin
         @(posedge i_clock);
         #1;
         chk("rst_flags", {125'd0, o_busy, o_done, o_error}, 128'd0);
      end
      chk("rst_data", o_data, 128'd0);
      @(negedge i_clock);
      i_reset = 1'b0;

      // Write then read back line 4; writes leave o_data alone.
      do_op("wr40", 1'b1, 32'h0000_0040, L1, 16'hFFFF, 1, 1'b1, 128'd0);
      do_op("rd_unwr", 1'b0, 32'h0000_0100, '0, 16'hFFFF, 3, 1'b0, '0);
      chk("rd_unwr_x", {127'd0, $isunknown(o_data)}, 128'd0);
      do_op("rd40", 1'b0, 32'h0000_0040, '0, 16'hFFFF, 3, 1'b1, L1);
      do_op("wr80", 1'b1, 32'h0000_0080, L2, 16'hFFFF, 1, 1'b1, L1);

      // Aliasing and ignored offset bits.
      do_op("rd_alias", 1'b0, 32'h0000_0040 + 32'd16384, '0, 16'hFFFF, 3, 1'b1, L1);
      do_op("rd_4c", 1'b0, 32'h0000_004C, '0, 16'hFFFF, 3, 1'b1, L1);
      do_op("rd80", 1'b0, 32'h8000_0080, '0, 16'hFFFF, 3, 1'b1, L2);

      // Read and write together while idle.
      @(negedge i_clock);
      i_address = 32'h0000_0040;
      i_data    = L3;
      i_read    = 1'b1;
      i_write   = 1'b1;
      @(posedge i_clock);
      #1;
      chk("err_pulse", {126'd0, o_error, o_busy}, 128'd2);
      i_read  = 1'b0;
      i_write = 1'b0;
      @(posedge i_clock);
      #1;
      chk("err_clear", {126'd0, o_error, o_busy}, 128'd0);
      do_op("rd40_post_err", 1'b0, 32'h0000_0040, '0, 16'hFFFF, 3, 1'b1, L1);

      // Continuous read request: accept every 5th edge, o_done every 5 cycles.
      do_op("wr10", 1'b1, 32'h0000_0010, L4, 16'hFFFF, 1, 1'b1, L1);
      @(negedge i_clock);
      i_address = 32'h0000_0010;
      i_read    = 1'b1;
      for (int c = 0; c < 16; c++) begin
         @(posedge i_clock);
         #1;
         done_v[c] = o_done;
         busy_v[c] = o_busy;
      end
      chk("stream_done", 128'(done_v), 128'h2108);
      chk("stream_busy", 128'(busy_v), 128'hBDEF);
      chk("stream_data", o_data, L4);
      i_read = 1'b0;
      for (int c = 0; c < 10 && o_busy; c++) begin
         @(posedge i_clock);
         #1;
      end
      chk("stream_drain", {127'd0, o_busy}, 128'd0);

      // Reset on the commit edge of a write drops the write.
      @(negedge i_clock);
      i_address = 32'h0000_0080;
      i_data    = L5;
      i_write   = 1'b1;
      @(posedge i_clock);
      #1;
      i_write = 1'b0;
      @(negedge i_clock);
      i_reset = 1'b1;
      @(posedge i_clock);
      #1;
      chk("rst_mid_flags", {125'd0, o_busy, o_done, o_error}, 128'd0);
      chk("rst_mid_data", o_data, 128'd0);
      @(negedge i_clock);
      i_reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge i_clock);
         #1;
         chk("rst_mid_nodone", {127'd0, o_done}, 128'd0);
      end
      do_op("rd80_post_rst", 1'b0, 32'h0000_0080, '0, 16'hFFFF, 3, 1'b1, L2);

`ifdef MAIN_MEMORY_BYTE_STROBE_EN
      do_op("be_zero", 1'b1, 32'h0000_0200, 128'd0, 16'hFFFF, 1, 1'b0, '0);
      do_op("be_low4", 1'b1, 32'h0000_0200, {128{1'b1}}, 16'h000F, 1, 1'b0, '0);
      do_op("be_rd", 1'b0, 32'h0000_0200, '0, 16'h0000, 3, 1'b1,
            128'h00000000_00000000_00000000_FFFFFFFF);
      do_op("be_none", 1'b1, 32'h0000_0200, L3, 16'h0000, 1, 1'b0, '0);
      do_op("be_rd2", 1'b0, 32'h0000_0200, '0, 16'hFFFF, 3, 1'b1,
            128'h00000000_00000000_00000000_FFFFFFFF);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
